// File: rtl/lane_deser_rx_if.sv
// Word-side handshake of the lane deserializer: reassembled word, valid and
// consumer ready.
interface lane_deser_rx_if #(
    parameter int WORD_W = 32
) ();
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/lane_deser_rx.sv
// Multi-lane serial receiver: reassembles LSB-first bits from LANES lanes into
// one WORD_W word per frame, with a one-deep output holding register.
module lane_deser_rx #(
    parameter int LANES  = 4,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              ser_in2,
    input  logic              ser_in3,
    input  logic              ser_in4,
    input  logic              start_i,
    input  logic              err_clr,
    output logic              frame_err,
    output logic              overrun,
    lane_deser_rx_if.master   rx_if
);

    localparam int BPL   = WORD_W / LANES;
    localparam int CNT_W = (BPL > 1) ? $clog2(BPL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPL - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0]   idx_s;
    logic               capture_s;
    logic               abort_s;
    logic               done_s;
    logic [3:0]         lane_s;
    logic [WORD_W-1:0]  buf_r;
    logic [WORD_W-1:0]  word_s;
    logic [WORD_W-1:0]  data_out_r;
    logic               data_valid_r;
    logic               frame_err_r;
    logic               overrun_r;

    assign lane_s = {ser_in4, ser_in3, ser_in2, ser_in};

    // State and bit-counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; a start marker always wins and restarts at bit 0.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_s       = '0;
        capture_s   = 1'b0;
        abort_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    capture_s = 1'b1;
                    if (LAST == '0) begin
                        done_s    = 1'b1;
                        cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                capture_s = 1'b1;
                if (start_i) begin
                    abort_s   = 1'b1;
                    cnt_nxt_s = CNT_W'(1);
                end else if (cnt_r == LAST) begin
                    idx_s       = cnt_r;
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    idx_s     = cnt_r;
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Merge this cycle's lane bits so the final bit is visible when the word loads.
    always_comb begin
        word_s = buf_r;
        for (int k = 0; k < LANES; k++) begin
            word_s[BPL*k + int'(idx_s)] = lane_s[k];
        end
    end

    // Partial-frame assembly buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_r <= '0;
        end else if (capture_s) begin
            buf_r <= word_s;
        end else begin
            buf_r <= buf_r;
        end
    end

    // Output holding register with drop-on-full and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (done_s && (!data_valid_r || rx_if.data_ready)) begin
                data_out_r   <= word_s;
                data_valid_r <= 1'b1;
            end else if (data_valid_r && rx_if.data_ready) begin
                data_valid_r <= 1'b0;
            end else begin
                data_valid_r <= data_valid_r;
            end

            if (done_s && data_valid_r && !rx_if.data_ready) begin
                overrun_r <= 1'b1;
            end else if (err_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end

            if (abort_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clr) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign rx_if.data_out   = data_out_r;
    assign rx_if.data_valid = data_valid_r;
    assign frame_err        = frame_err_r;
    assign overrun          = overrun_r;

endmodule

// File: tb/tb_lane_deser_rx.sv
// Directed bench for lane_deser_rx: stimulus pushes expected words into a
// scoreboard queue; a monitor pops and compares on every accepted word.
module tb_lane_deser_rx;

    logic clk;
    logic rst;
    logic ser_in, ser_in2, ser_in3, ser_in4;
    logic start_i;
    logic err_clr;
    logic frame_err;
    logic overrun;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    lane_deser_rx_if #(.WORD_W(32)) rx_if ();

    lane_deser_rx #(.LANES(4), .WORD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_in2   (ser_in2),
        .ser_in3   (ser_in3),
        .ser_in4   (ser_in4),
        .start_i   (start_i),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_if     (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive bits lo..hi of a frame; start_i accompanies bit 0 only.
    task automatic frame_bits(input logic [31:0] w, input int lo, input int hi);
        for (int b = lo; b <= hi; b++) begin
            start_i = (b == 0);
            ser_in  = w[b];
            ser_in2 = w[8 + b];
            ser_in3 = w[16 + b];
            ser_in4 = w[24 + b];
            tick();
        end
        start_i = 1'b0;
    endtask

    task automatic stimulus();
        rst = 1'b0; start_i = 1'b0; err_clr = 1'b0;
        ser_in = 1'b0; ser_in2 = 1'b0; ser_in3 = 1'b0; ser_in4 = 1'b0;
        rx_if.data_ready = 1'b1;
        tick(); tick();
        check("rst_valid", {31'd0, rx_if.data_valid}, 32'd0);
        check("rst_data", rx_if.data_out, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk); rst = 1'b1;
        tick();

        // Single frame: valid appears only on the bit-7 edge, for one cycle.
        sb.push_back(32'hDEADBEEF);
        frame_bits(32'hDEADBEEF, 0, 6);
        check("lat_not_early", {31'd0, rx_if.data_valid}, 32'd0);
        frame_bits(32'hDEADBEEF, 7, 7);
        check("single_valid", {31'd0, rx_if.data_valid}, 32'd1);
        check("single_data", rx_if.data_out, 32'hDEADBEEF);
        tick();
        check("single_one_cycle", {31'd0, rx_if.data_valid}, 32'd0);

        // Back-to-back frames.
        sb.push_back(32'h01234567);
        sb.push_back(32'h89ABCDEF);
        frame_bits(32'h01234567, 0, 7);
        frame_bits(32'h89ABCDEF, 0, 7);
        tick();
        check("b2b_frame_err", {31'd0, frame_err}, 32'd0);
        check("b2b_overrun", {31'd0, overrun}, 32'd0);

        // Overrun: second word dropped while the first is held.
        rx_if.data_ready = 1'b0;
        sb.push_back(32'h11111111);
        frame_bits(32'h11111111, 0, 7);
        frame_bits(32'h22222222, 0, 7);
        check("ovr_data_kept", rx_if.data_out, 32'h11111111);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_valid", {31'd0, rx_if.data_valid}, 32'd1);
        rx_if.data_ready = 1'b1;
        tick();
        check("ovr_drained", {31'd0, rx_if.data_valid}, 32'd0);

        // Early start at bit 4 aborts the frame.
        sb.push_back(32'hCAFEF00D);
        frame_bits(32'hFFFFFFFF, 0, 3);
        frame_bits(32'hCAFEF00D, 0, 7);
        check("abort_frame_err", {31'd0, frame_err}, 32'd1);
        check("abort_data", rx_if.data_out, 32'hCAFEF00D);
        tick();

        // err_clr clears both sticky flags.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_frame_err", {31'd0, frame_err}, 32'd0);
        check("clr_overrun", {31'd0, overrun}, 32'd0);

        // Abort in the same cycle as err_clr: the set wins.
        sb.push_back(32'hA5A55A5A);
        frame_bits(32'h00000000, 0, 1);
        err_clr = 1'b1;
        frame_bits(32'hA5A55A5A, 0, 0);
        err_clr = 1'b0;
        check("set_beats_clr", {31'd0, frame_err}, 32'd1);
        frame_bits(32'hA5A55A5A, 1, 7);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Completion while valid&ready: new word loads, valid stays high.
        rx_if.data_ready = 1'b0;
        sb.push_back(32'h0F0F0F0F);
        sb.push_back(32'h3C3CC3C3);
        frame_bits(32'h0F0F0F0F, 0, 7);
        frame_bits(32'h3C3CC3C3, 0, 6);
        rx_if.data_ready = 1'b1;
        frame_bits(32'h3C3CC3C3, 7, 7);
        check("simul_valid", {31'd0, rx_if.data_valid}, 32'd1);
        check("simul_data", rx_if.data_out, 32'h3C3CC3C3);
        check("simul_no_ovr", {31'd0, overrun}, 32'd0);
        tick();
        check("simul_drained", {31'd0, rx_if.data_valid}, 32'd0);

        // Reset mid-frame with a pending word and frame_err set.
        rx_if.data_ready = 1'b0;
        frame_bits(32'hFFFFFFFF, 0, 2);
        frame_bits(32'h77777777, 0, 7);
        frame_bits(32'hFFFFFFFF, 0, 4);
        check("pre_rst_valid", {31'd0, rx_if.data_valid}, 32'd1);
        check("pre_rst_frame_err", {31'd0, frame_err}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, rx_if.data_valid}, 32'd0);
        check("mid_rst_data", rx_if.data_out, 32'd0);
        check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk); rst = 1'b1;
        rx_if.data_ready = 1'b1;
        ser_in = 1'b1; ser_in2 = 1'b1; ser_in3 = 1'b1; ser_in4 = 1'b1;
        tick(); tick();
        check("no_start_ignored", {31'd0, rx_if.data_valid}, 32'd0);
        sb.push_back(32'h00000001);
        frame_bits(32'h00000001, 0, 7);
        check("post_rst_data", rx_if.data_out, 32'h00000001);
        tick(); tick();
        check("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (rst && rx_if.data_valid && rx_if.data_ready) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_word: got 0x%08h expected none", rx_if.data_out);
                        end else begin
                            check("sb_word", rx_if.data_out, sb.pop_front());
                        end
                    end
                end
            end
            begin
                stimulus();
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
